gf180_ram_word_seq: RTL and testbench

GF180_RAM_WORD_SEQ -- requirements
Module: gf180_ram_word_seq

---
 rtl/gf180_ram_seq_pkg.sv | 10 +
 rtl/gf180_ram_word_seq.sv | 84 ++++++++
 tb/tb_gf180_ram_word_seq.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/gf180_ram_seq_pkg.sv
// gf180_ram_seq_pkg: shared state encoding, geometry and idle strobe levels for gf180_ram_word_seq
package gf180_ram_seq_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;
    localparam int LANES = 4;
    localparam int RAM_AW = 9;
    localparam int WORD_AW = 7;
    localparam logic CEN_IDLE = 1'b1;
    localparam logic GWEN_IDLE = 1'b1;
    localparam logic [7:0] WEN_IDLE = 8'hFF;
endpackage

// File: rtl/gf180_ram_word_seq.sv
// gf180_ram_word_seq: 32-bit word port sequenced onto a 512x8 SRAM, one byte lane per cycle; GF180_RAM_SEQ_LANE_SKIP_EN idles disabled write lanes
module gf180_ram_word_seq
    import gf180_ram_seq_pkg::*;
(
    input  logic               CLK,
    input  logic               RESETN,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [WORD_AW-1:0] req_addr,
    input  logic [31:0]        req_wdata,
    input  logic [3:0]         req_be,
    output logic               rsp_valid,
    output logic [31:0]        rsp_rdata,
    output logic               ram_cen,
    output logic               ram_gwen,
    output logic [7:0]         ram_wen,
    output logic [RAM_AW-1:0]  ram_a,
    output logic [7:0]         ram_d,
    input  logic [7:0]         ram_q
);
    state_t state;
    logic [1:0] lane;
    logic [1:0] prev;
    logic we;
    logic [WORD_AW-1:0] addr;
    logic [31:0] wdata;
    logic [3:0] be;
    logic acc;
    logic wr_lane;

    assign prev = lane - 2'd1;
    assign req_ready = state == IDLE;
    assign rsp_valid = state == RESP;

    // Sequencer: latch request, walk four lanes, collect read bytes one cycle behind the SRAM access
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state <= IDLE;
            lane <= 2'd0;
            we <= 1'b0;
            addr <= '0;
            wdata <= '0;
            be <= '0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    we <= req_we;
                    addr <= req_addr;
                    wdata <= req_wdata;
                    be <= req_be;
                    lane <= 2'd0;
                    state <= ACCESS;
                end
                ACCESS: begin
                    if (!we && lane != 2'd0) rsp_rdata[{prev, 3'b000} +: 8] <= ram_q;
                    lane <= lane + 2'd1;
                    if (lane == 2'(LANES - 1)) state <= we ? RESP : CAPTURE;
                end
                CAPTURE: begin
                    rsp_rdata[31:24] <= ram_q;
                    state <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // SRAM strobes decoded purely from registered state so req_* never reaches the macro pins
    always_comb begin
        acc = state == ACCESS;
        wr_lane = we && be[lane];
`ifdef GF180_RAM_SEQ_LANE_SKIP_EN
        ram_cen = acc && (!we || be[lane]) ? 1'b0 : CEN_IDLE;
`else
        ram_cen = acc ? 1'b0 : CEN_IDLE;
`endif
        ram_gwen = acc && wr_lane ? 1'b0 : GWEN_IDLE;
        ram_wen = acc && wr_lane ? 8'h00 : WEN_IDLE;
        ram_a = acc ? {addr, lane} : '0;
        ram_d = acc ? wdata[{lane, 3'b000} +: 8] : '0;
    end
endmodule

// File: tb/tb_gf180_ram_word_seq.sv
// tb_gf180_ram_word_seq: directed and random word transactions against a word-level memory model
module tb_gf180_ram_word_seq;
    logic CLK = 1'b0;
    logic RESETN = 1'b0;
    logic req_valid = 1'b0;
    logic req_ready;
    logic req_we = 1'b0;
    logic [6:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0] req_be = '0;
    logic rsp_valid;
    logic [31:0] rsp_rdata;
    logic ram_cen;
    logic ram_gwen;
    logic [7:0] ram_wen;
    logic [8:0] ram_a;
    logic [7:0] ram_d;
    logic [7:0] ram_q;
    logic [7:0] q = '0;
    logic [7:0] sram [512];
    logic [31:0] ref_mem [128];
    logic [31:0] last_rdata;
    int total = 0;
    int fails = 0;

`ifdef GF180_RAM_SEQ_LANE_SKIP_EN
    localparam logic SKIP = 1'b1;
`else
    localparam logic SKIP = 1'b0;
`endif

    always #5 CLK = ~CLK;
    assign ram_q = q;

    gf180_ram_word_seq dut (
        .CLK(CLK), .RESETN(RESETN),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_cen(ram_cen), .ram_gwen(ram_gwen), .ram_wen(ram_wen),
        .ram_a(ram_a), .ram_d(ram_d), .ram_q(ram_q)
    );

    function automatic logic [7:0] seed_byte(int i);
        case (i)
            'h14: return 8'h11;
            'h15: return 8'h22;
            'h16: return 8'h33;
            'h17: return 8'h44;
            default: return 8'(i * 37 + 11);
        endcase
    endfunction

    // Behavioural 512x8 macro: active-low strobes, per-bit write mask, q registered after a read
    initial begin
        for (int i = 0; i < 512; i++) sram[i] = seed_byte(i);
        forever begin
            @(posedge CLK);
            if (!ram_cen) begin
                if (!ram_gwen) sram[ram_a] = (sram[ram_a] & ram_wen) | (ram_d & ~ram_wen);
                else q <= sram[ram_a];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic txn(input logic we, input logic [6:0] a, input logic [31:0] d, input logic [3:0] be, input bit hold);
        int lat;
        lat = we ? 5 : 6;
        @(negedge CLK);
        chk("ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_we = we;
        req_addr = a;
        req_wdata = d;
        req_be = be;
        for (int c = 1; c <= lat; c++) begin
            @(negedge CLK);
            if (!hold) begin
                req_valid = 1'($urandom);
                req_we = 1'($urandom);
                req_addr = 7'($urandom);
                req_wdata = $urandom;
                req_be = 4'($urandom);
            end
            chk("ready_busy", req_ready, 0);
            chk("rsp_valid", rsp_valid, 32'(c == lat));
            if (c <= 4) begin
                chk("ram_a", ram_a, {a, 2'(c - 1)});
                chk("ram_cen", ram_cen, (we && !be[c-1]) ? SKIP : 1'b0);
                chk("ram_gwen", ram_gwen, !(we && be[c-1]));
                chk("ram_wen", ram_wen, (we && be[c-1]) ? 8'h00 : 8'hFF);
                if (we && be[c-1]) chk("ram_d", ram_d, d[8*(c-1) +: 8]);
            end else begin
                chk("ram_cen_off", ram_cen, 1);
                chk("ram_a_off", ram_a, 0);
            end
        end
        if (we) begin
            for (int b = 0; b < 4; b++) if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
            chk("wr_keeps_rdata", rsp_rdata, last_rdata);
        end else begin
            chk("rd_data", rsp_rdata, ref_mem[a]);
            last_rdata = ref_mem[a];
        end
    endtask

    initial begin
        logic [31:0] d;
        for (int w = 0; w < 128; w++)
            ref_mem[w] = {seed_byte(4*w+3), seed_byte(4*w+2), seed_byte(4*w+1), seed_byte(4*w)};
        last_rdata = '0;
        #1;
        chk("rst_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_cen", ram_cen, 1);
        chk("rst_gwen", ram_gwen, 1);
        chk("rst_wen", ram_wen, 8'hFF);
        chk("rst_a", ram_a, 0);
        chk("rst_d", ram_d, 0);
        repeat (2) @(negedge CLK);
        RESETN = 1'b1;
        txn(1'b0, 7'h05, 32'h0, 4'h0, 1'b0);
        chk("read_0x05", rsp_rdata, 32'h44332211);
        txn(1'b1, 7'h7F, 32'hDEADBEEF, 4'hF, 1'b0);
        txn(1'b0, 7'h7F, 32'h0, 4'h0, 1'b0);
        chk("read_full_wr", rsp_rdata, 32'hDEADBEEF);
        txn(1'b1, 7'h7F, 32'h00000000, 4'b0101, 1'b0);
        txn(1'b0, 7'h7F, 32'h0, 4'h0, 1'b0);
        chk("read_partial_wr", rsp_rdata, 32'hDE00BE00);
        txn(1'b1, 7'h7F, 32'h12345678, 4'h0, 1'b0);
        txn(1'b0, 7'h7F, 32'h0, 4'h0, 1'b0);
        chk("read_be0_wr", rsp_rdata, 32'hDE00BE00);
        txn(1'b0, 7'h01, 32'h0, 4'h0, 1'b1);
        txn(1'b0, 7'h02, 32'h0, 4'h0, 1'b0);
        for (int n = 0; n < 40; n++) begin
            txn(1'($urandom), ($urandom % 2) ? 7'($urandom_range(0, 3)) : 7'($urandom), $urandom, 4'($urandom), 1'b0);
        end
        @(negedge CLK);
        req_valid = 1'b0;
        d = $urandom;
        @(negedge CLK);
        req_valid = 1'b1;
        req_we = 1'b1;
        req_addr = 7'h33;
        req_wdata = d;
        req_be = 4'hF;
        @(negedge CLK);
        req_valid = 1'b0;
        repeat (2) @(negedge CLK);
        chk("abort_lane2_a", ram_a, {7'h33, 2'd2});
        RESETN = 1'b0;
        #1;
        chk("abort_cen", ram_cen, 1);
        chk("abort_gwen", ram_gwen, 1);
        chk("abort_wen", ram_wen, 8'hFF);
        chk("abort_a", ram_a, 0);
        chk("abort_d", ram_d, 0);
        chk("abort_ready", req_ready, 1);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_rdata", rsp_rdata, 0);
        ref_mem[7'h33][15:0] = d[15:0];
        last_rdata = '0;
        @(negedge CLK);
        RESETN = 1'b1;
        repeat (6) begin
            @(negedge CLK);
            chk("abort_no_rsp", rsp_valid, 0);
        end
        txn(1'b0, 7'h33, 32'h0, 4'h0, 1'b0);
        @(negedge CLK);
        req_valid = 1'b0;
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
